// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with boundary-aligned divisor loads
// Three-state run/drain/idle control; divisor changes and stops only take effect at the period wrap.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             load,
    output logic             load_ack,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] active, active_n;
    logic [DIV_W-1:0] pending, pending_n;
    logic             pending_valid, pending_valid_n;
    logic             wrap, apply_div;
    logic             clk_out_n, tick_n;
    logic [DIV_W:0]   hi_n;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            active        <= DIV_DEF;
            pending       <= '0;
            pending_valid <= 1'b0;
            clk_out       <= 1'b0;
            tick          <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            active        <= active_n;
            pending       <= pending_n;
            pending_valid <= pending_valid_n;
            clk_out       <= clk_out_n;
            tick          <= tick_n;
            load_ack      <= apply_div;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        pending_n       = pending;
        pending_valid_n = pending_valid;

        wrap      = (state != IDLE) && (cnt == (active - ONE));
        // A pending divisor lands immediately when idle, otherwise only at a period boundary.
        apply_div = pending_valid && ((state == IDLE) || wrap);
        active_n  = apply_div ? pending : active;

        if (load) begin
            pending_n       = (div_val < DIV_MIN) ? DIV_MIN : div_val;
            pending_valid_n = 1'b1;
        end else if (apply_div) begin
            pending_valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (en) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                cnt_n = wrap ? '0 : cnt + ONE;
                if (!en) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // Re-enabling before the wrap keeps counting, so the waveform has no gap.
                if (en) begin
                    state_n = RUN;
                    cnt_n   = wrap ? '0 : cnt + ONE;
                end else if (wrap) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        hi_n      = ({1'b0, active_n} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        clk_out_n = (state_n != IDLE) && ({1'b0, cnt_n} < hi_n);
        tick_n    = clk_out_n & ~clk_out;
    end

    assign busy = (state != IDLE);

endmodule
